// File: rtl/fp_add_seq_ctrl_if.sv
// Operand/result handshake bundle for fp_add_seq_ctrl.
// The slave side is the adder; the master side is the issue/writeback logic.
interface fp_add_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [31:0] in_y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/fp_add_seq_ctrl.sv
// Multi-cycle single-precision adder: bit-serial alignment and normalization,
// truncating result, one operation in flight.
module fp_add_seq_ctrl #(
  parameter int unsigned MAX_SHIFT = 25
) (
  input  logic               clk,
  input  logic               rst_n,
  fp_add_seq_ctrl_if.slave   bus,
  output logic               busy
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  localparam logic [8:0] MAX_SHIFT_W = 9'(MAX_SHIFT);

  state_t      state_q, state_d;
  logic        sign_b_q, sign_b_d;
  logic        sign_l_q, sign_l_d;
  logic        sign_q, sign_d;
  logic [7:0]  exp_q, exp_d;
  logic [23:0] mb_q, mb_d;
  logic [23:0] ml_q, ml_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [24:0] sum_q, sum_d;
  logic [31:0] res_q, res_d;

  // Operand decode for the accepting cycle
  logic [7:0]  ex, ey;
  logic        x_lt_y;
  logic [8:0]  dif;
  logic [23:0] mx, my;
  logic        clamp;
  logic [7:0]  exp_inc;

  assign ex      = bus.in_x[30:23];
  assign ey      = bus.in_y[30:23];
  assign x_lt_y  = ex < ey;
  assign dif     = x_lt_y ? ({1'b0, ey} - {1'b0, ex}) : ({1'b0, ex} - {1'b0, ey});
  assign mx      = (ex != 8'd0) ? {1'b1, bus.in_x[22:0]} : '0;
  assign my      = (ey != 8'd0) ? {1'b1, bus.in_y[22:0]} : '0;
  assign clamp   = dif >= MAX_SHIFT_W;
  assign exp_inc = exp_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    sign_b_d = sign_b_q;
    sign_l_d = sign_l_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mb_d     = mb_q;
    ml_d     = ml_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    res_d    = res_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (ex == 8'hFF || ey == 8'hFF) begin
            res_d   = (ex == 8'hFF) ? bus.in_x : bus.in_y;
            state_d = DONE;
          end else begin
            // X wins exponent ties
            sign_b_d = x_lt_y ? bus.in_y[31] : bus.in_x[31];
            sign_l_d = x_lt_y ? bus.in_x[31] : bus.in_y[31];
            exp_d    = x_lt_y ? ey : ex;
            mb_d     = x_lt_y ? my : mx;
            ml_d     = clamp ? '0 : (x_lt_y ? mx : my);
            cnt_d    = clamp ? '0 : dif;
            state_d  = ALIGN;
          end
        end
      end

      ALIGN: begin
        if (cnt_q == 9'd0) begin
          state_d = ADD;
        end else begin
          ml_d  = ml_q >> 1;
          cnt_d = cnt_q - 9'd1;
        end
      end

      ADD: begin
        // Magnitude compare replaces negate-after-subtract; same result
        if (sign_b_q == sign_l_q) begin
          sum_d  = {1'b0, mb_q} + {1'b0, ml_q};
          sign_d = sign_b_q;
        end else if (mb_q >= ml_q) begin
          sum_d  = {1'b0, mb_q} - {1'b0, ml_q};
          sign_d = sign_b_q;
        end else begin
          sum_d  = {1'b0, ml_q} - {1'b0, mb_q};
          sign_d = sign_l_q;
        end
        state_d = NORM;
      end

      NORM: begin
        if (sum_q == 25'd0) begin
          res_d   = '0;
          state_d = DONE;
        end else if (sum_q[24]) begin
          sum_d = sum_q >> 1;
          exp_d = exp_inc;
          if (exp_inc == 8'hFF) begin
            res_d   = {sign_q, 8'hFF, 23'h0};
            state_d = DONE;
          end
        end else if (!sum_q[23]) begin
          if (exp_q == 8'd1) begin
            res_d   = {sign_q, 31'h0};
            state_d = DONE;
          end else begin
            sum_d = sum_q << 1;
            exp_d = exp_q - 8'd1;
          end
        end else begin
          res_d   = {sign_q, exp_q, sum_q[22:0]};
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sign_b_q <= 1'b0;
      sign_l_q <= 1'b0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mb_q     <= '0;
      ml_q     <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      sign_b_q <= sign_b_d;
      sign_l_q <= sign_l_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mb_q     <= mb_d;
      ml_q     <= ml_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      res_q    <= res_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_result = res_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_fp_add_seq_ctrl.sv
// Directed-vector bench for fp_add_seq_ctrl; latency counts edges after the
// accepting edge until out_valid is seen high.
module tb_fp_add_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   vectors = 0;
  int   miscompares = 0;

  fp_add_seq_ctrl_if bus ();

  fp_add_seq_ctrl #(.MAX_SHIFT(25)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic start_op(input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      vectors++; miscompares++;
      $display("FAIL accept_wait: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
    end
    bus.in_x = x;
    bus.in_y = y;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output logic busy_ok);
    lat = 0;
    busy_ok = busy;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output int lat, output logic busy_ok);
    start_op(x, y);
    wait_valid(lat, busy_ok);
    res = bus.out_result;
    release_result();
  endtask

  task automatic test_reset();
    #1;
    vectors++; if (bus.out_result !== 32'h0) begin miscompares++; $display("FAIL reset_result: got %h want 00000000", bus.out_result); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] r; int l; logic b;
    do_op(32'h3F800000, 32'h3F800000, r, l, b);
    vectors++; if (r !== 32'h40000000) begin miscompares++; $display("FAIL one_plus_one: got %h want 40000000", r); end
    vectors++; if (l !== 4) begin miscompares++; $display("FAIL one_plus_one_lat: got %0d want 4", l); end
    vectors++; if (b !== 1'b1) begin miscompares++; $display("FAIL one_plus_one_busy: busy dropped, got %b want 1", b); end
  endtask

  task automatic test_cancel();
    logic [31:0] r; int l; logic b;
    do_op(32'h3FC00000, 32'hBFC00000, r, l, b);
    vectors++; if (r !== 32'h00000000) begin miscompares++; $display("FAIL cancel: got %h want 00000000", r); end
    vectors++; if (l !== 3) begin miscompares++; $display("FAIL cancel_lat: got %0d want 3", l); end
  endtask

  task automatic test_sub_norm();
    logic [31:0] r; int l; logic b;
    do_op(32'h3F800000, 32'hBF400000, r, l, b);
    vectors++; if (r !== 32'h3E800000) begin miscompares++; $display("FAIL sub_norm: got %h want 3E800000", r); end
    vectors++; if (l !== 6) begin miscompares++; $display("FAIL sub_norm_lat: got %0d want 6", l); end
    do_op(32'hBF400000, 32'h3F800000, r, l, b);
    vectors++; if (r !== 32'h3E800000) begin miscompares++; $display("FAIL sub_norm_swap: got %h want 3E800000", r); end
    vectors++; if (l !== 6) begin miscompares++; $display("FAIL sub_norm_swap_lat: got %0d want 6", l); end
  endtask

  task automatic test_signs();
    logic [31:0] r; int l; logic b;
    // equal exponents, larger magnitude in the little slot: sign comes from little
    do_op(32'h3F800000, 32'hBFC00000, r, l, b);
    vectors++; if (r !== 32'hBF000000) begin miscompares++; $display("FAIL little_wins_sign: got %h want BF000000", r); end
    vectors++; if (l !== 4) begin miscompares++; $display("FAIL little_wins_sign_lat: got %0d want 4", l); end
    do_op(32'hBF800000, 32'h40000000, r, l, b);
    vectors++; if (r !== 32'h3F800000) begin miscompares++; $display("FAIL y_big: got %h want 3F800000", r); end
    vectors++; if (l !== 5) begin miscompares++; $display("FAIL y_big_lat: got %0d want 5", l); end
  endtask

  task automatic test_boundaries();
    logic [31:0] r; int l; logic b;
    do_op(32'h3F800000, 32'h30800000, r, l, b);
    vectors++; if (r !== 32'h3F800000) begin miscompares++; $display("FAIL clamp: got %h want 3F800000", r); end
    vectors++; if (l !== 3) begin miscompares++; $display("FAIL clamp_lat: got %0d want 3", l); end
    // exponent-255 path: out_valid is already high after the accepting edge
    do_op(32'h7F800000, 32'h3F800000, r, l, b);
    vectors++; if (r !== 32'h7F800000) begin miscompares++; $display("FAIL inf_pass: got %h want 7F800000", r); end
    vectors++; if (l !== 0) begin miscompares++; $display("FAIL inf_pass_lat: got %0d extra edges want 0", l); end
    do_op(32'h7F7FFFFF, 32'h7F7FFFFF, r, l, b);
    vectors++; if (r !== 32'h7F800000) begin miscompares++; $display("FAIL overflow: got %h want 7F800000", r); end
    vectors++; if (l !== 3) begin miscompares++; $display("FAIL overflow_lat: got %0d want 3", l); end
    do_op(32'h00800000, 32'h80C00000, r, l, b);
    vectors++; if (r !== 32'h80000000) begin miscompares++; $display("FAIL underflow: got %h want 80000000", r); end
    vectors++; if (l !== 3) begin miscompares++; $display("FAIL underflow_lat: got %0d want 3", l); end
  endtask

  task automatic test_backpressure();
    logic [31:0] r; int l; logic b;
    start_op(32'h3F800000, 32'h3F800000);
    wait_valid(l, b);
    vectors++; if (l !== 4) begin miscompares++; $display("FAIL bp_lat: got %0d want 4", l); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_x = 32'h40400000;
      bus.in_y = 32'hC0E00000;
      @(posedge clk);
      #1;
      vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.out_valid); end
      vectors++; if (bus.out_result !== 32'h40000000) begin miscompares++; $display("FAIL bp_result[%0d]: got %h want 40000000", i, bus.out_result); end
      vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    release_result();
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_result !== 32'h40000000) begin miscompares++; $display("FAIL bp_result_hold: got %h want 40000000", bus.out_result); end
    do_op(32'h3F800000, 32'hBF400000, r, l, b);
    vectors++; if (r !== 32'h3E800000) begin miscompares++; $display("FAIL bp_next: got %h want 3E800000", r); end
    vectors++; if (l !== 6) begin miscompares++; $display("FAIL bp_next_lat: got %0d want 6", l); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int l; logic b;
    start_op(32'h3F800000, 32'h3E800000);
    @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy: got %b want 1", busy); end
    #1;
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_result !== 32'h0) begin miscompares++; $display("FAIL mid_rst_result: got %h want 00000000", bus.out_result); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_ready: got %b want 1", bus.in_ready); end
    do_op(32'h3F800000, 32'h3F800000, r, l, b);
    vectors++; if (r !== 32'h40000000) begin miscompares++; $display("FAIL after_rst: got %h want 40000000", r); end
    vectors++; if (l !== 4) begin miscompares++; $display("FAIL after_rst_lat: got %0d want 4", l); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_cancel();
    test_sub_norm();
    test_signs();
    test_boundaries();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
